// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the 5-stage MIPS pipeline.
// Decoder and sequencer agree on these encodings.
package mips_ctrl_pkg;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_R_TYPE = 2'd2;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_2_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_sequencer_hazard_detect.sv
// Load-use hazard check between the load in EX
// and the source operands of the instruction in ID.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_dest_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rt_use_i,
  output logic              load_use_o
);

  logic dest_live;
  logic rs_hit;
  logic rt_hit;

  // r0 never carries a value, so a load to r0 cannot stall
  always_comb begin
    dest_live  = ex_dest_i != '0;
    rs_hit     = ex_dest_i == id_rs_i;
    rt_hit     = id_rt_use_i & (ex_dest_i == id_rt_i);
    load_use_o = ex_mem_read_i & dest_live & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// ID/EX, EX/MEM, MEM/WB control registers with
// load-use stall, branch/jump redirect and stall counter.
module pipe_ctrl_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [1:0]        id_alu_op,
  input  logic              id_reg_dst,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_2_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_jump,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_alu_zero,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [REG_AW-1:0] mem_dest,
  output logic              mem_reg_write,
  output logic              wb_reg_write,
  output logic              wb_mem_2_reg,
  output logic [REG_AW-1:0] wb_dest,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              if_id_flush,
  output logic              pc_src_branch,
  output logic              pc_src_jump,
  output logic [CNT_W-1:0]  hazard_cnt
);

  ctrl_t             id_ctrl;
  ctrl_t             ex_d, ex_q;
  ctrl_t             mem_q, wb_q;
  logic [REG_AW-1:0] id_dest;
  logic [REG_AW-1:0] ex_dest_d, ex_dest_q;
  logic [REG_AW-1:0] mem_dest_q, wb_dest_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              rt_use;
  logic              load_use;
  logic              taken;
  logic              stall;
  logic              jump_go;
  logic              unused_wb;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard (
    .ex_mem_read_i(ex_q.mem_read),
    .ex_dest_i    (ex_dest_q),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_rt_use_i  (rt_use),
    .load_use_o   (load_use)
  );

  // Pack the decoded bundle; writes to r0 are dropped here
  always_comb begin
    id_ctrl.alu_op    = id_alu_op;
    id_ctrl.reg_dst   = id_reg_dst;
    id_ctrl.branch    = id_branch;
    id_ctrl.mem_read  = id_mem_read;
    id_ctrl.mem_2_reg = id_mem_2_reg;
    id_ctrl.mem_write = id_mem_write;
    id_ctrl.alu_src   = id_alu_src;
    id_ctrl.reg_write = id_reg_write;
    id_ctrl.jump      = id_jump;
    id_dest = id_reg_dst ? id_rd : id_rt;
    rt_use  = id_reg_dst | id_branch | id_mem_write;
    if (id_dest == '0) begin
      id_ctrl.reg_write = 1'b0;
    end
  end

  // Redirect priority: taken branch, then stall, then jump
  always_comb begin
    taken   = ex_q.branch & ex_alu_zero;
    stall   = load_use & ~taken;
    jump_go = id_jump & ~taken & ~load_use;
    ex_d      = id_ctrl;
    ex_dest_d = id_dest;
    if (taken | load_use | id_jump) begin
      ex_d      = BUBBLE;
      ex_dest_d = '0;
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stage registers; MEM and WB always advance
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ex_q       <= BUBBLE;
      mem_q      <= BUBBLE;
      wb_q       <= BUBBLE;
      ex_dest_q  <= '0;
      mem_dest_q <= '0;
      wb_dest_q  <= '0;
      cnt_q      <= '0;
    end else begin
      ex_q       <= ex_d;
      mem_q      <= ex_q;
      wb_q       <= mem_q;
      ex_dest_q  <= ex_dest_d;
      mem_dest_q <= ex_dest_q;
      wb_dest_q  <= mem_dest_q;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_alu_op      = ex_q.alu_op;
  assign ex_alu_src     = ex_q.alu_src;
  assign mem_mem_read   = mem_q.mem_read;
  assign mem_mem_write  = mem_q.mem_write;
  assign mem_dest       = mem_dest_q;
  assign mem_reg_write  = mem_q.reg_write;
  assign wb_reg_write   = wb_q.reg_write;
  assign wb_mem_2_reg   = wb_q.mem_2_reg;
  assign wb_dest        = wb_dest_q;
  assign pc_write_en    = ~stall;
  assign if_id_write_en = ~stall;
  assign if_id_flush    = taken | jump_go;
  assign pc_src_branch  = taken;
  assign pc_src_jump    = jump_go;
  assign hazard_cnt     = cnt_q;

  assign unused_wb = ^{wb_q.alu_op, wb_q.reg_dst,
                       wb_q.branch, wb_q.mem_read,
                       wb_q.mem_write, wb_q.alu_src,
                       wb_q.jump};

endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
// Random + directed bench for pipe_ctrl_sequencer
// against a stage-list reference model.
module tb_pipe_ctrl_sequencer;

  localparam int CNT_W  = 4;
  localparam int REG_AW = 5;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic              clk;
  logic              arst_n;
  logic [1:0]        id_alu_op;
  logic              id_reg_dst;
  logic              id_branch;
  logic              id_mem_read;
  logic              id_mem_2_reg;
  logic              id_mem_write;
  logic              id_alu_src;
  logic              id_reg_write;
  logic              id_jump;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              ex_alu_zero;
  logic [1:0]        ex_alu_op;
  logic              ex_alu_src;
  logic              mem_mem_read;
  logic              mem_mem_write;
  logic [REG_AW-1:0] mem_dest;
  logic              mem_reg_write;
  logic              wb_reg_write;
  logic              wb_mem_2_reg;
  logic [REG_AW-1:0] wb_dest;
  logic              pc_write_en;
  logic              if_id_write_en;
  logic              if_id_flush;
  logic              pc_src_branch;
  logic              pc_src_jump;
  logic [CNT_W-1:0]  hazard_cnt;

  pipe_ctrl_sequencer #(
    .CNT_W (CNT_W),
    .REG_AW(REG_AW)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .id_alu_op     (id_alu_op),
    .id_reg_dst    (id_reg_dst),
    .id_branch     (id_branch),
    .id_mem_read   (id_mem_read),
    .id_mem_2_reg  (id_mem_2_reg),
    .id_mem_write  (id_mem_write),
    .id_alu_src    (id_alu_src),
    .id_reg_write  (id_reg_write),
    .id_jump       (id_jump),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .ex_alu_zero   (ex_alu_zero),
    .ex_alu_op     (ex_alu_op),
    .ex_alu_src    (ex_alu_src),
    .mem_mem_read  (mem_mem_read),
    .mem_mem_write (mem_mem_write),
    .mem_dest      (mem_dest),
    .mem_reg_write (mem_reg_write),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_2_reg  (wb_mem_2_reg),
    .wb_dest       (wb_dest),
    .pc_write_en   (pc_write_en),
    .if_id_write_en(if_id_write_en),
    .if_id_flush   (if_id_flush),
    .pc_src_branch (pc_src_branch),
    .pc_src_jump   (pc_src_jump),
    .hazard_cnt    (hazard_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int alu_op;
    int alu_src;
    int mem_read;
    int mem_write;
    int mem_2_reg;
    int reg_write;
    int branch;
    int dest;
  } stg_t;

  stg_t st[3];
  int   cnt;
  int   n_vec;
  int   n_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic stg_t empty();
    stg_t s;
    s = '{0, 0, 0, 0, 0, 0, 0, 0};
    return s;
  endfunction

  function automatic int m_taken();
    return (st[0].branch != 0 && ex_alu_zero) ? 1 : 0;
  endfunction

  function automatic int m_lu();
    int use_rt;
    use_rt = (id_reg_dst | id_branch | id_mem_write) ? 1 : 0;
    if (st[0].mem_read == 0 || st[0].dest == 0) return 0;
    if (st[0].dest == int'(id_rs)) return 1;
    if (use_rt != 0 && st[0].dest == int'(id_rt)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) st[i] = empty();
    cnt = 0;
  endtask

  task automatic check_all();
    int tk, lu, stl, jg;
    tk  = m_taken();
    lu  = m_lu();
    stl = (lu != 0 && tk == 0) ? 1 : 0;
    jg  = (id_jump && tk == 0 && lu == 0) ? 1 : 0;
    chk("ex_alu_op", ex_alu_op, st[0].alu_op);
    chk("ex_alu_src", ex_alu_src, st[0].alu_src);
    chk("mem_read", mem_mem_read, st[1].mem_read);
    chk("mem_write", mem_mem_write, st[1].mem_write);
    chk("mem_dest", mem_dest, st[1].dest);
    chk("mem_reg_write", mem_reg_write, st[1].reg_write);
    chk("wb_reg_write", wb_reg_write, st[2].reg_write);
    chk("wb_mem_2_reg", wb_mem_2_reg, st[2].mem_2_reg);
    chk("wb_dest", wb_dest, st[2].dest);
    chk("pc_write_en", pc_write_en, 1 - stl);
    chk("if_id_write_en", if_id_write_en, 1 - stl);
    chk("if_id_flush", if_id_flush, (tk | jg) != 0);
    chk("pc_src_branch", pc_src_branch, tk);
    chk("pc_src_jump", pc_src_jump, jg);
    chk("hazard_cnt", hazard_cnt, cnt);
  endtask

  task automatic drive(input logic [1:0] op,
                       input logic rdst, br, mr, m2r,
                       input logic mw, asrc, rw, jmp,
                       input logic [4:0] rs, rt, rd,
                       input logic z);
    @(negedge clk);
    id_alu_op    = op;
    id_reg_dst   = rdst;
    id_branch    = br;
    id_mem_read  = mr;
    id_mem_2_reg = m2r;
    id_mem_write = mw;
    id_alu_src   = asrc;
    id_reg_write = rw;
    id_jump      = jmp;
    id_rs        = rs;
    id_rt        = rt;
    id_rd        = rd;
    ex_alu_zero  = z;
    #1;
    check_all();
  endtask

  task automatic edge_step();
    int tk, lu;
    stg_t n;
    tk = m_taken();
    lu = m_lu();
    n  = empty();
    if (tk == 0 && lu == 0 && !id_jump) begin
      n.alu_op    = id_alu_op;
      n.alu_src   = id_alu_src;
      n.mem_read  = id_mem_read;
      n.mem_write = id_mem_write;
      n.mem_2_reg = id_mem_2_reg;
      n.branch    = id_branch;
      n.dest      = id_reg_dst ? id_rd : id_rt;
      n.reg_write = (id_reg_write && n.dest != 0) ? 1 : 0;
    end
    if (lu != 0 && tk == 0 && cnt < SAT) cnt++;
    @(posedge clk);
    st[2] = st[1];
    st[1] = st[0];
    st[0] = n;
    #1;
  endtask

  task automatic nop(input logic z);
    drive(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, z);
  endtask

  task automatic do_reset();
    @(negedge clk);
    id_alu_op = '0; id_reg_dst = 0; id_branch = 0;
    id_mem_read = 0; id_mem_2_reg = 0; id_mem_write = 0;
    id_alu_src = 0; id_reg_write = 0; id_jump = 0;
    id_rs = '0; id_rt = '0; id_rd = '0; ex_alu_zero = 0;
    #2;
    arst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    arst_n = 1'b0;
    model_reset();
    do_reset();
    chk("rst_pc_we", pc_write_en, 1);
    chk("rst_cnt", hazard_cnt, 0);

    // add r3 then lw r4: latency through MEM/WB
    drive(2'd2, 1, 0, 0, 0, 0, 0, 1, 0, 1, 2, 3, 0);
    edge_step();
    drive(2'd0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 4, 0, 0);
    edge_step();
    chk("add_mem_dest", mem_dest, 3);
    nop(0);
    edge_step();
    chk("add_wb_dest", wb_dest, 3);
    chk("add_wb_we", wb_reg_write, 1);
    chk("lw_mem_read", mem_mem_read, 1);
    nop(0);
    edge_step();
    chk("lw_wb_m2r", wb_mem_2_reg, 1);
    chk("lw_wb_dest", wb_dest, 4);

    // load-use stall on rs
    do_reset();
    drive(2'd0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 5, 0, 0);
    edge_step();
    drive(2'd2, 1, 0, 0, 0, 0, 0, 1, 0, 5, 6, 7, 0);
    chk("lu_pc_we", pc_write_en, 0);
    chk("lu_ifid_we", if_id_write_en, 0);
    edge_step();
    chk("lu_cnt", hazard_cnt, 1);
    chk("lu_bubble", ex_alu_op, 0);
    // load to r0 never stalls
    drive(2'd0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    edge_step();
    drive(2'd2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7, 0);
    chk("lu_r0_pc_we", pc_write_en, 1);
    edge_step();

    // taken branch beats a load-use hazard
    do_reset();
    drive(2'd1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    edge_step();
    drive(2'd2, 1, 0, 0, 0, 0, 0, 1, 0, 5, 6, 7, 1);
    chk("br_src", pc_src_branch, 1);
    chk("br_flush", if_id_flush, 1);
    chk("br_pc_we", pc_write_en, 1);
    edge_step();
    chk("br_cnt", hazard_cnt, 0);
    chk("br_bubble", ex_alu_op, 0);
    drive(2'd1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    edge_step();
    drive(2'd2, 1, 0, 0, 0, 0, 0, 1, 0, 5, 6, 7, 0);
    chk("nbr_flush", if_id_flush, 0);
    chk("nbr_pc_we", pc_write_en, 0);
    edge_step();

    // jump: flush, enters EX as bubble
    do_reset();
    drive(2'd2, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    chk("j_src", pc_src_jump, 1);
    chk("j_flush", if_id_flush, 1);
    edge_step();
    chk("j_bubble_op", ex_alu_op, 0);
    chk("j_bubble_src", ex_alu_src, 0);
    drive(2'd1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    edge_step();
    drive(2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    chk("jbr_jump", pc_src_jump, 0);
    chk("jbr_branch", pc_src_branch, 1);
    edge_step();

    // saturation of the stall counter
    do_reset();
    for (int i = 0; i < SAT + 4; i++) begin
      drive(2'd0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 5, 0, 0);
      edge_step();
      drive(2'd2, 1, 0, 0, 0, 0, 0, 1, 0, 5, 6, 7, 0);
      edge_step();
    end
    chk("sat_cnt", hazard_cnt, SAT);

    // random traffic with a mid-stream reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      drive(2'($urandom_range(0, 2)),
            1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom),
            1'($urandom_range(0, 5) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom));
      edge_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
